conv_mac_pipe: RTL and testbench

- Parametrised, pipelined KxK convolution multiply-accumulate engine for the CNN datapath; next generation of the combinational 5x5 element-wise multiplier.
- Each accepted beat carries one KxK input window and one KxK filter. The block multiplies element-wise, reduces the products to one sum, and accumulates that sum across input channels.
- When the beat marked last is accepted, the block emits one saturated signed result with valid/ready backpressure.

---
 rtl/conv_mac_pipe.sv | 188 ++++++++++++++++++
 tb/tb_conv_mac_pipe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_pipe.sv
// ============================================================================
// conv_mac_pipe : 4-stage KxK convolution MAC, saturating channel accumulation
// Optional macro CONV_MAC_RELU_EN applies ReLU to the result.  Rev 1.0
// ============================================================================
`default_nettype none

module conv_mac_pipe #(
  parameter int IN_WIDTH  = 8,
  parameter int W_WIDTH   = 8,
  parameter int KSIZE     = 5,
  parameter int OUT_WIDTH = 32,
  parameter int ACC_GUARD = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [IN_WIDTH*KSIZE*KSIZE-1:0]     in_window,
  input  logic [W_WIDTH*KSIZE*KSIZE-1:0]      in_filter,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic                                out_sat
);

  localparam int c_N  = KSIZE * KSIZE;
  localparam int c_PW = IN_WIDTH + W_WIDTH;
  localparam int c_TW = c_PW + $clog2(c_N);
  localparam int c_AW = OUT_WIDTH + ACC_GUARD;

  localparam logic signed [c_AW-1:0] c_ACC_MAX = {1'b0, {(c_AW-1){1'b1}}};
  localparam logic signed [c_AW-1:0] c_ACC_MIN = {1'b1, {(c_AW-1){1'b0}}};
  localparam logic signed [c_AW-1:0] c_OUT_MAX = {{(ACC_GUARD+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [c_AW-1:0] c_OUT_MIN = {{(ACC_GUARD+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic                    w_en;
  logic signed [c_PW-1:0]  w_prod [c_N];
  logic signed [c_PW-1:0]  r_prod [c_N];
  logic                    r_v1, r_last1;
  logic signed [c_TW-1:0]  w_row [KSIZE];
  logic signed [c_TW-1:0]  r_row [KSIZE];
  logic                    r_v2, r_last2;
  logic signed [c_TW-1:0]  w_total;
  logic signed [c_TW-1:0]  r_total;
  logic                    r_v3, r_last3;

  logic signed [c_AW-1:0]      r_acc;
  logic                        r_sticky;
  logic                        r_first;
  logic signed [c_AW-1:0]      w_total_ext;
  logic signed [c_AW:0]        w_sum;
  logic                        w_acc_ovf;
  logic signed [c_AW-1:0]      w_acc_next;
  logic                        w_clamp_hi, w_clamp_lo;
  logic signed [OUT_WIDTH-1:0] w_clamped;
  logic signed [OUT_WIDTH-1:0] w_result;
  logic                        r_out_valid;
  logic signed [OUT_WIDTH-1:0] r_out_data;
  logic                        r_out_sat;

  // One global enable: a stalled output freezes the whole pipe.
  assign w_en     = !r_out_valid | out_ready;
  assign in_ready = w_en;

  always_comb begin
    for (int i = 0; i < c_N; i++) begin
      w_prod[i] = c_PW'($signed(in_window[IN_WIDTH*i +: IN_WIDTH])) *
                  c_PW'($signed(in_filter[W_WIDTH*i +: W_WIDTH]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      for (int i = 0; i < c_N; i++) r_prod[i] <= '0;
    end else if (w_en) begin
      r_v1    <= in_valid;
      r_last1 <= in_last;
      for (int i = 0; i < c_N; i++) r_prod[i] <= w_prod[i];
    end
  end

  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      w_row[r] = '0;
      for (int c = 0; c < KSIZE; c++) begin
        w_row[r] = w_row[r] + c_TW'(r_prod[r*KSIZE+c]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      for (int r = 0; r < KSIZE; r++) r_row[r] <= '0;
    end else if (w_en) begin
      r_v2    <= r_v1;
      r_last2 <= r_last1;
      for (int r = 0; r < KSIZE; r++) r_row[r] <= w_row[r];
    end
  end

  always_comb begin
    w_total = '0;
    for (int r = 0; r < KSIZE; r++) w_total = w_total + r_row[r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3    <= 1'b0;
      r_last3 <= 1'b0;
      r_total <= '0;
    end else if (w_en) begin
      r_v3    <= r_v2;
      r_last3 <= r_last2;
      r_total <= w_total;
    end
  end

  // One extra bit on the add exposes accumulator overflow.
  assign w_total_ext = c_AW'(r_total);
  assign w_sum       = {r_acc[c_AW-1], r_acc} + {w_total_ext[c_AW-1], w_total_ext};
  assign w_acc_ovf   = !r_first && (w_sum[c_AW] != w_sum[c_AW-1]);

  always_comb begin
    if (r_first)        w_acc_next = w_total_ext;
    else if (w_acc_ovf) w_acc_next = w_sum[c_AW] ? c_ACC_MIN : c_ACC_MAX;
    else                w_acc_next = w_sum[c_AW-1:0];
  end

  assign w_clamp_hi = w_acc_next > c_OUT_MAX;
  assign w_clamp_lo = w_acc_next < c_OUT_MIN;

  always_comb begin
    if (w_clamp_hi)      w_clamped = c_OUT_MAX[OUT_WIDTH-1:0];
    else if (w_clamp_lo) w_clamped = c_OUT_MIN[OUT_WIDTH-1:0];
    else                 w_clamped = w_acc_next[OUT_WIDTH-1:0];
  end

  always_comb begin
`ifdef CONV_MAC_RELU_EN
    w_result = w_clamped[OUT_WIDTH-1] ? '0 : w_clamped;
`else
    w_result = w_clamped;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_first     <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_en) begin
      if (r_v3) begin
        if (r_last3) begin
          r_acc    <= '0;
          r_sticky <= 1'b0;
          r_first  <= 1'b1;
        end else begin
          r_acc    <= w_acc_next;
          r_sticky <= r_sticky | w_acc_ovf;
          r_first  <= 1'b0;
        end
      end
      // en implies the held result (if any) is being taken this cycle.
      if (r_v3 && r_last3) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
        r_out_sat   <= r_sticky | w_acc_ovf | w_clamp_hi | w_clamp_lo;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

`default_nettype wire

// File: tb/tb_conv_mac_pipe.sv
// ============================================================================
// tb_conv_mac_pipe : checks a 32-bit and a 16-bit instance against a
// channel-accumulating dot-product reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_conv_mac_pipe;

  localparam int IW = 8;
  localparam int WW = 8;
  localparam int K  = 5;
  localparam int N  = K * K;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_last;
  logic [IW*N-1:0]   in_window;
  logic [WW*N-1:0]   in_filter;
  logic              out_ready;
  logic              in_ready_a, out_valid_a, out_sat_a;
  logic [31:0]       out_data_a;
  logic              in_ready_b, out_valid_b, out_sat_b;
  logic [15:0]       out_data_b;

  conv_mac_pipe #(.IN_WIDTH(IW), .W_WIDTH(WW), .KSIZE(K), .OUT_WIDTH(32), .ACC_GUARD(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_window(in_window), .in_filter(in_filter), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_sat(out_sat_a));

  conv_mac_pipe #(.IN_WIDTH(IW), .W_WIDTH(WW), .KSIZE(K), .OUT_WIDTH(16), .ACC_GUARD(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_window(in_window), .in_filter(in_filter), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_sat(out_sat_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic longint relu(longint v);
`ifdef CONV_MAC_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  // ---------------- reference model ----------------
  typedef struct { longint data; bit sat; } res_t;
  res_t   q_a[$];
  res_t   q_b[$];
  longint m_acc[2];
  bit     m_sticky[2];
  bit     m_first[2];

  function automatic longint dot();
    longint s = 0;
    for (int i = 0; i < N; i++)
      s += longint'($signed(in_window[i*IW +: IW])) * longint'($signed(in_filter[i*WW +: WW]));
    return s;
  endfunction

  function automatic void model_beat(int k, longint d, bit last);
    longint amax, amin, omax, omin, acc;
    res_t   r;
    amax = (64'sd1 <<< ((k == 0) ? 39 : 23)) - 1;
    amin = -amax - 1;
    omax = (64'sd1 <<< ((k == 0) ? 31 : 15)) - 1;
    omin = -omax - 1;
    acc  = m_first[k] ? d : m_acc[k] + d;
    if (acc > amax)      begin acc = amax; m_sticky[k] = 1'b1; end
    else if (acc < amin) begin acc = amin; m_sticky[k] = 1'b1; end
    if (last) begin
      r.sat  = m_sticky[k];
      r.data = acc;
      if (r.data > omax)      begin r.data = omax; r.sat = 1'b1; end
      else if (r.data < omin) begin r.data = omin; r.sat = 1'b1; end
      r.data = relu(r.data);
      if (k == 0) q_a.push_back(r);
      else        q_b.push_back(r);
      m_acc[k] = 0; m_sticky[k] = 1'b0; m_first[k] = 1'b1;
    end else begin
      m_acc[k] = acc; m_first[k] = 1'b0;
    end
  endfunction

  // ---------------- monitor / scoreboard (mid-cycle) ----------------
  bit     st_a, st_b;
  longint hd_a, hd_b;
  bit     hs_a, hs_b;
  res_t   e_a, e_b;
  longint d_beat;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_sticky[k] = 1'b0; m_first[k] = 1'b1; end
      q_a.delete(); q_b.delete();
      st_a = 1'b0; st_b = 1'b0;
    end else begin
      if (st_a) begin
        check("hold_valid_a", longint'(out_valid_a), 1);
        check("hold_data_a", longint'($signed(out_data_a)), hd_a);
        check("hold_sat_a", longint'(out_sat_a), longint'(hs_a));
      end
      if (st_b) begin
        check("hold_data_b", longint'($signed(out_data_b)), hd_b);
        check("hold_sat_b", longint'(out_sat_b), longint'(hs_b));
      end
      st_a = out_valid_a && !out_ready; hd_a = longint'($signed(out_data_a)); hs_a = out_sat_a;
      st_b = out_valid_b && !out_ready; hd_b = longint'($signed(out_data_b)); hs_b = out_sat_b;
      if (out_valid_a && out_ready) begin
        if (q_a.size() == 0) check("spurious_out_a", 1, 0);
        else begin
          e_a = q_a.pop_front();
          check("sb_data_a", longint'($signed(out_data_a)), e_a.data);
          check("sb_sat_a", longint'(out_sat_a), longint'(e_a.sat));
        end
      end
      if (out_valid_b && out_ready) begin
        if (q_b.size() == 0) check("spurious_out_b", 1, 0);
        else begin
          e_b = q_b.pop_front();
          check("sb_data_b", longint'($signed(out_data_b)), e_b.data);
          check("sb_sat_b", longint'(out_sat_b), longint'(e_b.sat));
        end
      end
      if (in_valid && in_ready_a) begin
        d_beat = dot();
        model_beat(0, d_beat, in_last);
        model_beat(1, d_beat, in_last);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_uniform(input int w, input int f, input bit last);
    for (int i = 0; i < N; i++) begin
      in_window[i*IW +: IW] = w[IW-1:0];
      in_filter[i*WW +: WW] = f[WW-1:0];
    end
    in_last  = last;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_uniform(input int w, input int f, input bit last);
    bit ok = 1'b0;
    set_uniform(w, f, last);
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      ok = in_ready_a;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid_a && cyc < 20);
    if (!out_valid_a) check("out_timeout", 0, 1);
  endtask

  typedef struct {
    int     w;
    int     f;
    longint exp_a;
    bit     sat_a;
    longint exp_b;
    bit     sat_b;
  } vec_t;

  vec_t tbl[6];
  int   cyc;
  int   pulses;

  initial begin
    tbl[0] = '{1,    2,    50,      1'b0, 50,     1'b0};
    tbl[1] = '{-1,   1,    -25,     1'b0, -25,    1'b0};
    tbl[2] = '{127,  127,  403225,  1'b0, 32767,  1'b1};
    tbl[3] = '{-128, 127,  -406400, 1'b0, -32768, 1'b1};
    tbl[4] = '{-128, -128, 409600,  1'b0, 32767,  1'b1};
    tbl[5] = '{0,    -77,  0,       1'b0, 0,      1'b0};

    rst_n = 1'b0; out_ready = 1'b1; in_window = '0; in_filter = '0; idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid_a), 0);
    check("rst_out_data", longint'(out_data_a), 0);
    check("rst_out_sat", longint'(out_sat_a), 0);
    check("rst_in_ready", longint'(in_ready_a), 1);
    check("rst_out_valid_b", longint'(out_valid_b), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single-beat frames from the table, latency and value
    for (int v = 0; v < 6; v++) begin
      send_uniform(tbl[v].w, tbl[v].f, 1'b1);
      idle();
      wait_out(cyc);
      check("tbl_latency", cyc, 4);
      check("tbl_data_a", longint'($signed(out_data_a)), relu(tbl[v].exp_a));
      check("tbl_sat_a", longint'(out_sat_a), longint'(tbl[v].sat_a));
      check("tbl_data_b", longint'($signed(out_data_b)), relu(tbl[v].exp_b));
      check("tbl_sat_b", longint'(out_sat_b), longint'(tbl[v].sat_b));
      @(posedge clk); #1;
    end

    // three-channel frame, one pulse only
    send_uniform(3, -1, 1'b0);
    send_uniform(2, 2, 1'b0);
    send_uniform(1, 1, 1'b1);
    idle();
    wait_out(cyc);
    check("frame3_data", longint'($signed(out_data_a)), 50);
    check("frame3_sat", longint'(out_sat_a), 0);
    @(posedge clk); #1;
    pulses = 0;
    repeat (6) begin @(negedge clk); if (out_valid_a) pulses++; end
    check("frame3_single_pulse", pulses, 0);
    @(posedge clk); #1;

    // 30-channel accumulation: overflows the 16-bit instance only
    for (int b = 1; b <= 30; b++) send_uniform(127, 127, b == 30);
    idle();
    wait_out(cyc);
    check("sat30_data_a", longint'($signed(out_data_a)), 12096750);
    check("sat30_sat_a", longint'(out_sat_a), 0);
    check("sat30_data_b", longint'($signed(out_data_b)), 32767);
    check("sat30_sat_b", longint'(out_sat_b), 1);
    @(posedge clk); #1;

    // backpressure with continuous single-beat frames
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_uniform(k + 1, 1, 1'b1);
      @(negedge clk);
      if (out_valid_a) check("bp_in_ready_low", longint'(in_ready_a), 0);
      @(posedge clk); #1;
    end
    idle();
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("bp_drained_a", q_a.size(), 0);

    // reset in the middle of a frame
    send_uniform(3, 3, 1'b0);
    send_uniform(3, 3, 1'b0);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", longint'(out_valid_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_uniform(1, 1, 1'b1);
    idle();
    wait_out(cyc);
    check("midrst_data", longint'($signed(out_data_a)), 25);
    check("midrst_latency", cyc, 4);
    @(posedge clk); #1;

    // randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 4) != 0;
      in_last   = ($urandom % 3) == 0;
      for (int i = 0; i < N; i++) begin
        in_window[i*IW +: IW] = IW'($urandom);
        in_filter[i*WW +: WW] = WW'($urandom);
      end
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    idle();
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("final_queue_a_empty", q_a.size(), 0);
    check("final_queue_b_empty", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
